// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and shadow-entry layout for pipe_hazard_ctrl
// Holds the EX operand forwarding-select encodings and the packed bit layout
// of one shadow-pipeline entry: six flag bits, then rd, rs and rt selects.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Flag bit positions inside a shadow entry.
    localparam int E_VALID   = 0;
    localparam int E_WR      = 1;
    localparam int E_LOAD    = 2;
    localparam int E_HALT    = 3;
    localparam int E_RS_USED = 4;
    localparam int E_RT_USED = 5;
    localparam int E_NFLAGS  = 6;

    // Register selects sit above the flags: rd, then rs, then rt.
    localparam int E_RD_LSB = E_NFLAGS;

    function automatic int rs_lsb(input int sel_w);
        return E_NFLAGS + sel_w;
    endfunction

    function automatic int rt_lsb(input int sel_w);
        return E_NFLAGS + 2 * sel_w;
    endfunction

    function automatic int entry_w(input int sel_w);
        return E_NFLAGS + 3 * sel_w;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/control bundle between datapath and pipe_hazard_ctrl
// master: datapath side, drives decode fields, redirect and mem_stall, reads controls.
// slave : hazard controller, reads decode fields, drives enables, bubbles,
//         forwarding selects, halted, stall_cnt and err.
interface pipe_hazard_ctrl_if #(
    parameter int REG_SEL_W = 3,
    parameter int CNT_W     = 16
);
    logic                 dec_valid;
    logic [REG_SEL_W-1:0] dec_rs;
    logic [REG_SEL_W-1:0] dec_rt;
    logic                 dec_rs_used;
    logic                 dec_rt_used;
    logic [REG_SEL_W-1:0] dec_rd;
    logic                 dec_wr;
    logic                 dec_load;
    logic                 dec_halt;
    logic                 dec_br;
    logic                 redirect;
    logic                 mem_stall;

    logic                 pc_en;
    logic                 ftch_dec_en;
    logic                 dec_exe_en;
    logic                 exe_mem_en;
    logic                 mem_wb_en;
    logic                 ftch_dec_flush;
    logic                 dec_exe_bubble;
    logic                 mem_wb_bubble;
    logic [1:0]           fwd_a_sel;
    logic [1:0]           fwd_b_sel;
    logic                 halted;
    logic [CNT_W-1:0]     stall_cnt;
    logic                 err;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used, dec_rd,
               dec_wr, dec_load, dec_halt, dec_br, redirect, mem_stall,
        input  pc_en, ftch_dec_en, dec_exe_en, exe_mem_en, mem_wb_en,
               ftch_dec_flush, dec_exe_bubble, mem_wb_bubble,
               fwd_a_sel, fwd_b_sel, halted, stall_cnt, err
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used, dec_rd,
               dec_wr, dec_load, dec_halt, dec_br, redirect, mem_stall,
        output pc_en, ftch_dec_en, dec_exe_en, exe_mem_en, mem_wb_en,
               ftch_dec_flush, dec_exe_bubble, mem_wb_bubble,
               fwd_a_sel, fwd_b_sel, halted, stall_cnt, err
    );

endinterface

// File: rtl/hz_shadow_stage.sv
// rtl/hz_shadow_stage.sv - one shadow-pipeline entry with enable, bubble and sync reset
// Ports: clk, rst (synchronous, active-high); en_i advances the entry;
// bubble_i loads an all-zero (invalid) entry instead of d_i; q_o is the held entry.
module hz_shadow_stage
    import pipe_pkg::*;
#(
    parameter int W = entry_w(3)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;
    logic [W-1:0] entry_d;

    always_comb begin
        entry_d = entry_q;
        if (en_i) begin
            entry_d = bubble_i ? '0 : d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding, stall and halt control
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries the
// decode-stage instruction fields, redirect and mem_stall in, and the four
// pipeline-register enables, flush/bubble controls, EX forwarding selects,
// halted, stall_cnt and err out. All outputs are combinational from the
// shadow pipeline state and the current inputs.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_SEL_W = 3,
    parameter int FWD       = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int EW   = entry_w(REG_SEL_W);
    localparam int RS_L = rs_lsb(REG_SEL_W);
    localparam int RT_L = rt_lsb(REG_SEL_W);

    logic [EW-1:0] dec_e, ex_e, mem_e, wb_e;
    logic          hit_rs, hit_rt, hz, full_chk;
    logic          halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Entry is a valid writer of register r.
    function automatic logic writes(input logic [EW-1:0] e, input logic [REG_SEL_W-1:0] r);
        return e[E_VALID] && e[E_WR] && (e[E_RD_LSB +: REG_SEL_W] == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_SEL_W-1:0] r,
                                           input logic [EW-1:0] m, input logic [EW-1:0] w);
        if (FWD == 0 || !used) return FWD_RF;
        if (writes(m, r))      return FWD_MEM;
        if (writes(w, r))      return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        dec_e                        = '0;
        dec_e[E_VALID]               = bus.dec_valid;
        dec_e[E_WR]                  = bus.dec_wr;
        dec_e[E_LOAD]                = bus.dec_load;
        dec_e[E_HALT]                = bus.dec_halt;
        dec_e[E_RS_USED]             = bus.dec_rs_used;
        dec_e[E_RT_USED]             = bus.dec_rt_used;
        dec_e[E_RD_LSB +: REG_SEL_W] = bus.dec_rd;
        dec_e[RS_L +: REG_SEL_W]     = bus.dec_rs;
        dec_e[RT_L +: REG_SEL_W]     = bus.dec_rt;
    end

    hz_shadow_stage #(.W(EW)) u_ex (
        .clk(clk), .rst(rst), .en_i(bus.dec_exe_en), .bubble_i(bus.dec_exe_bubble),
        .d_i(dec_e), .q_o(ex_e)
    );
    hz_shadow_stage #(.W(EW)) u_mem (
        .clk(clk), .rst(rst), .en_i(bus.exe_mem_en), .bubble_i(1'b0),
        .d_i(ex_e), .q_o(mem_e)
    );
    hz_shadow_stage #(.W(EW)) u_wb (
        .clk(clk), .rst(rst), .en_i(bus.mem_wb_en), .bubble_i(bus.mem_wb_bubble),
        .d_i(mem_e), .q_o(wb_e)
    );

    // Branches read Rs in decode, and without forwarding the register file has
    // no write-through, so those cases must wait until the writer leaves WB.
    // With forwarding only a load in EX cannot supply its result in time.
    always_comb begin
        full_chk = (FWD == 0) || bus.dec_br;
        if (full_chk) begin
            hit_rs = writes(ex_e, bus.dec_rs) || writes(mem_e, bus.dec_rs) || writes(wb_e, bus.dec_rs);
            hit_rt = writes(ex_e, bus.dec_rt) || writes(mem_e, bus.dec_rt) || writes(wb_e, bus.dec_rt);
        end else begin
            hit_rs = writes(ex_e, bus.dec_rs) && ex_e[E_LOAD];
            hit_rt = writes(ex_e, bus.dec_rt) && ex_e[E_LOAD];
        end
        hz = bus.dec_valid && ((bus.dec_rs_used && hit_rs) || (bus.dec_rt_used && hit_rt));
    end

    always_comb begin
        bus.pc_en          = 1'b1;
        bus.ftch_dec_en    = 1'b1;
        bus.dec_exe_en     = 1'b1;
        bus.exe_mem_en     = 1'b1;
        bus.mem_wb_en      = 1'b1;
        bus.ftch_dec_flush = 1'b0;
        bus.dec_exe_bubble = 1'b0;
        bus.mem_wb_bubble  = 1'b0;
        if (halted_q) begin
            bus.pc_en       = 1'b0;
            bus.ftch_dec_en = 1'b0;
            bus.dec_exe_en  = 1'b0;
            bus.exe_mem_en  = 1'b0;
            bus.mem_wb_en   = 1'b0;
        end else if (bus.mem_stall) begin
            // Everything up to MEM freezes; WB drains and takes a bubble.
            bus.pc_en         = 1'b0;
            bus.ftch_dec_en   = 1'b0;
            bus.dec_exe_en    = 1'b0;
            bus.exe_mem_en    = 1'b0;
            bus.mem_wb_bubble = 1'b1;
        end else if (hz) begin
            bus.pc_en          = 1'b0;
            bus.ftch_dec_en    = 1'b0;
            bus.dec_exe_bubble = 1'b1;
        end else if (bus.redirect) begin
            bus.ftch_dec_flush = 1'b1;
        end
    end

    always_comb begin
        bus.fwd_a_sel = fwd_sel(ex_e[E_RS_USED], ex_e[RS_L +: REG_SEL_W], mem_e, wb_e);
        bus.fwd_b_sel = fwd_sel(ex_e[E_RT_USED], ex_e[RT_L +: REG_SEL_W], mem_e, wb_e);
    end

    always_comb begin
        halted_d    = halted_q || (wb_e[E_VALID] && wb_e[E_HALT] && bus.mem_wb_en);
        stall_cnt_d = stall_cnt_q;
        if ((hz || bus.mem_stall) && !halted_q && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.halted    = halted_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.err       = bus.redirect && halted_q;

    // Every entry carries the full field set; not every stage reads every field.
    logic unused_fields;
    assign unused_fields = ^{ex_e, mem_e, wb_e};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (FWD=1 and FWD=0/CNT_W=2)
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [2:0] rd;
        logic       wr;
        logic       load;
        logic       halt;
        logic [2:0] rs;
        logic       rs_used;
        logic [2:0] rt;
        logic       rt_used;
        logic       br;
        logic       redirect;
        logic       mem_stall;
    } in_t;

    // ctrl = {pc_en, ftch_dec_en, dec_exe_en, exe_mem_en, mem_wb_en, flush, de_bubble, mw_bubble}
    typedef struct packed {
        logic [7:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        halted;
        logic [15:0] cnt;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_HZ   = 8'b00111_010;
    localparam logic [7:0] C_MS   = 8'b00001_001;
    localparam logic [7:0] C_RD   = 8'b11111_100;
    localparam logic [7:0] C_HALT = 8'b00000_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  in0, in1;
    out_t out0, out1;
    int   n_vec = 0;
    int   n_fail = 0;

    pipe_hazard_ctrl_if #(.REG_SEL_W(3), .CNT_W(16)) bus1 ();
    pipe_hazard_ctrl_if #(.REG_SEL_W(3), .CNT_W(2))  bus0 ();

    pipe_hazard_ctrl #(.REG_SEL_W(3), .FWD(1), .CNT_W(16)) u_fwd (.clk(clk), .rst(in1.rst), .bus(bus1));
    pipe_hazard_ctrl #(.REG_SEL_W(3), .FWD(0), .CNT_W(2))  u_nof (.clk(clk), .rst(in0.rst), .bus(bus0));

    assign bus1.dec_valid = in1.valid;    assign bus0.dec_valid = in0.valid;
    assign bus1.dec_rd = in1.rd;          assign bus0.dec_rd = in0.rd;
    assign bus1.dec_wr = in1.wr;          assign bus0.dec_wr = in0.wr;
    assign bus1.dec_load = in1.load;      assign bus0.dec_load = in0.load;
    assign bus1.dec_halt = in1.halt;      assign bus0.dec_halt = in0.halt;
    assign bus1.dec_rs = in1.rs;          assign bus0.dec_rs = in0.rs;
    assign bus1.dec_rs_used = in1.rs_used; assign bus0.dec_rs_used = in0.rs_used;
    assign bus1.dec_rt = in1.rt;          assign bus0.dec_rt = in0.rt;
    assign bus1.dec_rt_used = in1.rt_used; assign bus0.dec_rt_used = in0.rt_used;
    assign bus1.dec_br = in1.br;          assign bus0.dec_br = in0.br;
    assign bus1.redirect = in1.redirect;  assign bus0.redirect = in0.redirect;
    assign bus1.mem_stall = in1.mem_stall; assign bus0.mem_stall = in0.mem_stall;

    assign out1 = {bus1.pc_en, bus1.ftch_dec_en, bus1.dec_exe_en, bus1.exe_mem_en, bus1.mem_wb_en,
                   bus1.ftch_dec_flush, bus1.dec_exe_bubble, bus1.mem_wb_bubble,
                   bus1.fwd_a_sel, bus1.fwd_b_sel, bus1.halted, bus1.stall_cnt, bus1.err};
    assign out0 = {bus0.pc_en, bus0.ftch_dec_en, bus0.dec_exe_en, bus0.exe_mem_en, bus0.mem_wb_en,
                   bus0.ftch_dec_flush, bus0.dec_exe_bubble, bus0.mem_wb_bubble,
                   bus0.fwd_a_sel, bus0.fwd_b_sel, bus0.halted, 14'd0, bus0.stall_cnt, bus0.err};

    function automatic in_t i_nop();
        in_t x;
        x = '0;
        return x;
    endfunction

    function automatic in_t i_op(input logic [2:0] rd, input logic wr, input logic load,
                                 input logic [2:0] rs, input logic rsu,
                                 input logic [2:0] rt, input logic rtu);
        in_t x;
        x = '0;
        x.valid = 1'b1; x.rd = rd; x.wr = wr; x.load = load;
        x.rs = rs; x.rs_used = rsu; x.rt = rt; x.rt_used = rtu;
        return x;
    endfunction

    function automatic in_t i_halt();
        in_t x;
        x = '0;
        x.valid = 1'b1; x.halt = 1'b1;
        return x;
    endfunction

    function automatic in_t i_br(input logic [2:0] rs);
        in_t x;
        x = '0;
        x.valid = 1'b1; x.br = 1'b1; x.rs = rs; x.rs_used = 1'b1;
        return x;
    endfunction

    function automatic vec_t row(input in_t i, input logic redir, input logic ms, input logic [7:0] c,
                                 input logic [1:0] fa, input logic [1:0] fb, input logic h,
                                 input int cnt, input logic err);
        vec_t v;
        v.i = i; v.i.redirect = redir; v.i.mem_stall = ms;
        v.o.ctrl = c; v.o.fa = fa; v.o.fb = fb; v.o.halted = h;
        v.o.cnt = cnt[15:0]; v.o.err = err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string nm, input int idx, input bit sel, input vec_t v);
        out_t got;
        tick();
        if (sel) in1 = v.i; else in0 = v.i;
        #3;
        got = sel ? out1 : out0;
        n_vec++;
        if (got !== v.o) begin
            n_fail++;
            $display("FAIL %s row %0d: got ctrl=%b fa=%b fb=%b halted=%b cnt=%0d err=%b, want ctrl=%b fa=%b fb=%b halted=%b cnt=%0d err=%b",
                     nm, idx, got.ctrl, got.fa, got.fb, got.halted, got.cnt, got.err,
                     v.o.ctrl, v.o.fa, v.o.fb, v.o.halted, v.o.cnt, v.o.err);
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    vec_t ta[$];
    vec_t tb[$];
    vec_t v;

    initial begin
        // FWD=1 sequence: forward from MEM, load-use, mem_stall vs redirect,
        // branch hazard vs redirect, halt, err, reset while halted.
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 0 reset state
        ta.push_back(row(i_op(1,1,0, 0,0, 0,0),    0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 1 add r1
        ta.push_back(row(i_op(2,1,0, 1,1, 5,1),    0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 2 add r2,r1,r5
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b01, 2'b00, 0, 0, 0)); // 3 r1 from MEM
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 4
        ta.push_back(row(i_op(3,1,1, 0,0, 0,0),    0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 5 ld r3
        ta.push_back(row(i_op(4,1,0, 3,1, 3,1),    0, 0, C_HZ,  2'b00, 2'b00, 0, 0, 0)); // 6 load-use
        ta.push_back(row(i_op(4,1,0, 3,1, 3,1),    0, 0, C_RUN, 2'b00, 2'b00, 0, 1, 0)); // 7 released
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b10, 2'b10, 0, 1, 0)); // 8 r3 from WB
        ta.push_back(row(i_op(6,1,0, 4,1, 0,0),    1, 1, C_MS,  2'b00, 2'b00, 0, 1, 0)); // 9 stall+redirect
        ta.push_back(row(i_op(6,1,0, 4,1, 0,0),    1, 1, C_MS,  2'b00, 2'b00, 0, 2, 0)); // 10
        ta.push_back(row(i_op(6,1,0, 4,1, 0,0),    1, 0, C_RD,  2'b00, 2'b00, 0, 3, 0)); // 11 redirect taken
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b10, 2'b00, 0, 3, 0)); // 12 r4 from WB
        ta.push_back(row(i_br(6),                  1, 0, C_HZ,  2'b00, 2'b00, 0, 3, 0)); // 13 br on MEM writer
        ta.push_back(row(i_br(6),                  1, 0, C_HZ,  2'b00, 2'b00, 0, 4, 0)); // 14 br on WB writer
        ta.push_back(row(i_br(6),                  1, 0, C_RD,  2'b00, 2'b00, 0, 5, 0)); // 15 br resolves
        ta.push_back(row(i_halt(),                 0, 0, C_RUN, 2'b00, 2'b00, 0, 5, 0)); // 16 halt in decode
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 5, 0)); // 17
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 5, 0)); // 18
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 5, 0)); // 19 halt in WB
        ta.push_back(row(i_nop(),                  1, 1, C_HALT,2'b00, 2'b00, 1, 5, 1)); // 20 halted, err
        ta.push_back(row(i_nop(),                  0, 1, C_HALT,2'b00, 2'b00, 1, 5, 0)); // 21 no count when halted
        v = row(i_nop(),                           0, 0, C_HALT,2'b00, 2'b00, 1, 5, 0);  // 22 rst asserted
        v.i.rst = 1'b1;
        ta.push_back(v);
        ta.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 23 after rst

        // FWD=0, CNT_W=2: three-cycle dependency stall, saturation, unused/invalid sources.
        tb.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 0
        tb.push_back(row(i_op(5,1,0, 0,0, 0,0),    0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0)); // 1 wr r5
        tb.push_back(row(i_op(7,1,0, 5,1, 5,1),    0, 0, C_HZ,  2'b00, 2'b00, 0, 0, 0)); // 2 writer in EX
        tb.push_back(row(i_op(7,1,0, 5,1, 5,1),    0, 0, C_HZ,  2'b00, 2'b00, 0, 1, 0)); // 3 writer in MEM
        tb.push_back(row(i_op(7,1,0, 5,1, 5,1),    0, 0, C_HZ,  2'b00, 2'b00, 0, 2, 0)); // 4 writer in WB
        tb.push_back(row(i_op(7,1,0, 5,1, 5,1),    0, 0, C_RUN, 2'b00, 2'b00, 0, 3, 0)); // 5 released
        tb.push_back(row(i_nop(),                  0, 1, C_MS,  2'b00, 2'b00, 0, 3, 0)); // 6 saturated
        tb.push_back(row(i_nop(),                  0, 1, C_MS,  2'b00, 2'b00, 0, 3, 0)); // 7
        tb.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 3, 0)); // 8
        tb.push_back(row(i_op(1,1,0, 0,0, 0,0),    0, 0, C_RUN, 2'b00, 2'b00, 0, 3, 0)); // 9 wr r1
        tb.push_back(row(i_op(0,0,0, 1,0, 2,1),    0, 0, C_RUN, 2'b00, 2'b00, 0, 3, 0)); // 10 rs=r1 unused
        v = row(i_op(0,0,0, 1,1, 0,0),             0, 0, C_RUN, 2'b00, 2'b00, 0, 3, 0);  // 11 not valid
        v.i.valid = 1'b0;
        tb.push_back(v);
        tb.push_back(row(i_op(0,0,0, 1,1, 0,0),    0, 0, C_HZ,  2'b00, 2'b00, 0, 3, 0)); // 12 r1 in WB
        tb.push_back(row(i_nop(),                  0, 0, C_RUN, 2'b00, 2'b00, 0, 3, 0)); // 13

        in0 = '0; in0.rst = 1'b1;
        in1 = '0; in1.rst = 1'b1;
        tick();
        tick();

        foreach (ta[k]) apply("fwd1", k, 1'b1, ta[k]);
        foreach (tb[k]) apply("fwd0", k, 1'b0, tb[k]);

        // rst during a stall clears the shadow pipeline and the counter.
        tick(); in0 = i_op(5,1,0, 0,0, 0,0);
        tick(); in0 = i_op(6,1,0, 5,1, 0,0);
        #3 chk("rst_mid_stall_hz", int'(bus0.pc_en), 0);
        tick(); in0.rst = 1'b1;
        tick(); in0.rst = 1'b0;
        #3;
        chk("rst_mid_stall_pc_en", int'(bus0.pc_en), 1);
        chk("rst_mid_stall_cnt", int'(bus0.stall_cnt), 0);
        chk("rst_mid_stall_halted", int'(bus0.halted), 0);

        // FWD=1 branch reading an EX writer waits 3 cycles, redirect ignored meanwhile.
        begin
            int  stalls;
            int  flush_in_stall;
            bit  done;
            stalls = 0; flush_in_stall = 0; done = 0;
            tick(); in1 = i_op(2,1,0, 0,0, 0,0);
            tick(); in1 = i_br(2); in1.redirect = 1'b1;
            for (int k = 0; k < 8 && !done; k++) begin
                #3;
                if (bus1.pc_en) begin
                    done = 1;
                end else begin
                    stalls++;
                    if (bus1.ftch_dec_flush) flush_in_stall++;
                    tick();
                end
            end
            chk("br_ex_stalls", stalls, 3);
            chk("br_flush_during_stall", flush_in_stall, 0);
            chk("br_flush_after", int'(bus1.ftch_dec_flush), 1);
            tick(); in1 = i_nop();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
